// File: rtl/controle_magnetron_if.sv
// controle_magnetron_if: button/door/timer levels into the magnetron
// controller and its registered status back out to the datapath/display.
interface controle_magnetron_if;
  logic       startn;
  logic       stopn;
  logic       clearn;
  logic       door_closed;
  logic       timer_done;
  logic       mag_on;
  logic [1:0] state;
  logic       interlock;

  // Front end / test driver side: drives the levels, observes the status
  modport master (
    output startn, stopn, clearn, door_closed, timer_done,
    input  mag_on, state, interlock
  );

  // Controller side
  modport slave (
    input  startn, stopn, clearn, door_closed, timer_done,
    output mag_on, state, interlock
  );
endinterface

// File: rtl/controle_magnetron.sv
// controle_magnetron: magnetron enable controller (IDLE/COOK/PAUSE/DONE).
// Optional macro MAG_SYNC_EN: when defined, every input level passes
// through a 2-flop synchronizer first (3-cycle input-to-output latency);
// when undefined the inputs are decoded directly (1-cycle latency).
// Reset is synchronous, active-low.
module controle_magnetron (
  input  logic                 clk,
  input  logic                 resetn,
  controle_magnetron_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] COOK  = 2'b01;
  localparam logic [1:0] PAUSE = 2'b10;
  localparam logic [1:0] DONE  = 2'b11;

  logic       startn_s;
  logic       stopn_s;
  logic       clearn_s;
  logic       door_closed_s;
  logic       timer_done_s;
  logic       req_s;
  logic       interlock_s;
  logic [1:0] next_state_s;
  logic [1:0] state_r;
  logic       mag_on_r;
  logic       interlock_r;

`ifdef MAG_SYNC_EN
  // Stage [0] captures the raw level, stage [1] feeds the decoder.
  logic [1:0] startn_sync_r;
  logic [1:0] stopn_sync_r;
  logic [1:0] clearn_sync_r;
  logic [1:0] door_closed_sync_r;
  logic [1:0] timer_done_sync_r;

  // Two-flop synchronizers; reset loads the inactive level of each input
  always_ff @(posedge clk) begin
    if (!resetn) begin
      startn_sync_r      <= 2'b11;
      stopn_sync_r       <= 2'b11;
      clearn_sync_r      <= 2'b11;
      door_closed_sync_r <= 2'b00;
      timer_done_sync_r  <= 2'b00;
    end else begin
      startn_sync_r      <= {startn_sync_r[0],      bus.startn};
      stopn_sync_r       <= {stopn_sync_r[0],       bus.stopn};
      clearn_sync_r      <= {clearn_sync_r[0],      bus.clearn};
      door_closed_sync_r <= {door_closed_sync_r[0], bus.door_closed};
      timer_done_sync_r  <= {timer_done_sync_r[0],  bus.timer_done};
    end
  end

  assign startn_s      = startn_sync_r[1];
  assign stopn_s       = stopn_sync_r[1];
  assign clearn_s      = clearn_sync_r[1];
  assign door_closed_s = door_closed_sync_r[1];
  assign timer_done_s  = timer_done_sync_r[1];
`else
  assign startn_s      = bus.startn;
  assign stopn_s       = bus.stopn;
  assign clearn_s      = bus.clearn;
  assign door_closed_s = bus.door_closed;
  assign timer_done_s  = bus.timer_done;
`endif

  // Start is a level; any blocking condition suppresses it, and holding it
  // lets cooking resume by itself once the block clears.
  assign req_s       = ~startn_s & door_closed_s & ~timer_done_s & stopn_s & clearn_s;
  assign interlock_s = ~startn_s & clearn_s & (~door_closed_s | timer_done_s | ~stopn_s);

  // Next-state decode: clear, then timer expiry, then door/stop, then start
  always_comb begin
    next_state_s = state_r;
    if (!clearn_s) begin
      next_state_s = IDLE;
    end else begin
      case (state_r)
        COOK: begin
          if (timer_done_s) begin
            next_state_s = DONE;
          end else if (!door_closed_s || !stopn_s) begin
            next_state_s = PAUSE;
          end else begin
            next_state_s = COOK;
          end
        end
        IDLE, PAUSE, DONE: begin
          if (req_s) begin
            next_state_s = COOK;
          end else begin
            next_state_s = state_r;
          end
        end
        default: next_state_s = IDLE;
      endcase
    end
  end

  // State and output registers; mag_on is a flop so the door path never
  // reaches the power stage combinationally
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r     <= IDLE;
      mag_on_r    <= 1'b0;
      interlock_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      mag_on_r    <= (next_state_s == COOK);
      interlock_r <= interlock_s;
    end
  end

  assign bus.state     = state_r;
  assign bus.mag_on    = mag_on_r;
  assign bus.interlock = interlock_r;

endmodule

// File: tb/tb_controle_magnetron.sv
// tb_controle_magnetron: directed test-plan steps followed by random level
// stimulus, every cycle compared against a rule-level reference model.
module tb_controle_magnetron;

`ifdef MAG_SYNC_EN
  localparam int LAT  = 3;
  localparam bit SYNC = 1'b1;
`else
  localparam int LAT  = 1;
  localparam bit SYNC = 1'b0;
`endif

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  controle_magnetron_if bus ();

  controle_magnetron dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: state as text-level names, inputs as a record
  typedef struct packed {
    logic startn, stopn, clearn, door, timer;
  } in_t;

  localparam in_t INACT = '{startn: 1'b1, stopn: 1'b1, clearn: 1'b1, door: 1'b0, timer: 1'b0};

  int   m_state;      // 0 idle, 1 cook, 2 pause, 3 done
  logic m_mag;
  logic m_il;
  in_t  m_s1, m_s2;

  function automatic int rule_next(int st, in_t i);
    bit start_req;
    start_req = !i.startn && i.door && !i.timer && i.stopn && i.clearn;
    if (!i.clearn)                       return 0;
    if (st == 1 && i.timer)              return 3;
    if (st == 1 && (!i.door || !i.stopn)) return 2;
    if (st != 1 && start_req)            return 1;
    return st;
  endfunction

  function automatic in_t cur_in();
    in_t i;
    i.startn = bus.startn; i.stopn = bus.stopn; i.clearn = bus.clearn;
    i.door   = bus.door_closed; i.timer = bus.timer_done;
    return i;
  endfunction

  task automatic model_edge();
    in_t eff;
    if (!resetn) begin
      m_state = 0; m_mag = 1'b0; m_il = 1'b0;
      m_s1 = INACT; m_s2 = INACT;
    end else begin
      eff     = SYNC ? m_s2 : cur_in();
      m_state = rule_next(m_state, eff);
      m_mag   = (m_state == 1);
      m_il    = !eff.startn && eff.clearn && (!eff.door || eff.timer || !eff.stopn);
      m_s2    = m_s1;
      m_s1    = cur_in();
    end
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: model follows the edge, outputs compared mid-cycle
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("model_state", bus.state, 2'(m_state));
    chk("model_mag_on", {1'b0, bus.mag_on}, {1'b0, m_mag});
    chk("model_interlock", {1'b0, bus.interlock}, {1'b0, m_il});
  endtask

  task automatic settle();
    for (int k = 0; k < LAT; k++) tick();
  endtask

  task automatic drive(input logic s, input logic p, input logic c, input logic d, input logic t);
    bus.startn = s; bus.stopn = p; bus.clearn = c; bus.door_closed = d; bus.timer_done = t;
  endtask

  task automatic expect_out(input string tag, input logic [1:0] st, input logic mg, input logic il);
    chk({tag, "_state"}, bus.state, st);
    chk({tag, "_mag_on"}, {1'b0, bus.mag_on}, {1'b0, mg});
    chk({tag, "_interlock"}, {1'b0, bus.interlock}, {1'b0, il});
  endtask

  initial begin
    checks = 0; errors = 0;
    m_state = 0; m_mag = 1'b0; m_il = 1'b0; m_s1 = INACT; m_s2 = INACT;
    resetn = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);

    // Reset release
    tick(); tick();
    expect_out("reset", 2'b00, 1'b0, 1'b0);
    resetn = 1'b1;
    tick();
    expect_out("reset_release", 2'b00, 1'b0, 1'b0);

    // Door interlock sequence
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    settle();
    expect_out("start", 2'b01, 1'b1, 1'b0);
    bus.door_closed = 1'b0;
    settle();
    expect_out("door_open", 2'b10, 1'b0, 1'b1);
    bus.door_closed = 1'b1;
    settle();
    expect_out("door_reclose", 2'b01, 1'b1, 1'b0);

    // Stop pulse for 5 cycles with start held
    bus.stopn = 1'b0;
    settle();
    expect_out("stop", 2'b10, 1'b0, 1'b1);
    for (int k = LAT; k < 5; k++) tick();
    expect_out("stop_hold", 2'b10, 1'b0, 1'b1);
    bus.stopn = 1'b1;
    settle();
    expect_out("stop_release", 2'b01, 1'b1, 1'b0);

    // Timer expiry, then DONE held, then resume when timer clears
    bus.timer_done = 1'b1;
    settle();
    expect_out("timer_done", 2'b11, 1'b0, 1'b1);
    tick(); tick();
    expect_out("done_hold", 2'b11, 1'b0, 1'b1);
    bus.timer_done = 1'b0;
    settle();
    expect_out("done_restart", 2'b01, 1'b1, 1'b0);

    // Clear beats timer and door in the same cycle
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    settle();
    expect_out("clear_prio", 2'b00, 1'b0, 1'b0);

    // Reset in the middle of cooking with start still held
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    settle();
    expect_out("recook", 2'b01, 1'b1, 1'b0);
    resetn = 1'b0;
    tick();
    expect_out("reset_midcook", 2'b00, 1'b0, 1'b0);
    resetn = 1'b1;
    for (int k = 0; k < LAT + 2; k++) tick();
    expect_out("after_reset", 2'b01, 1'b1, 1'b0);

    // Random level stimulus, each input held for a few cycles
    for (int n = 0; n < 150; n++) begin
      drive(($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0,
            ($urandom_range(0, 9) < 2) ? 1'b0 : 1'b1,
            ($urandom_range(0, 19) < 1) ? 1'b0 : 1'b1,
            ($urandom_range(0, 9) < 2) ? 1'b0 : 1'b1,
            ($urandom_range(0, 9) < 2) ? 1'b1 : 1'b0);
      resetn = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
      for (int k = 0; k < int'($urandom_range(1, 4)); k++) tick();
    end
    resetn = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
